// File: rtl/ll_step_engine.sv
// ll_step_engine: digit-serial BCD lunar-lander physics step over altitude, velocity and fuel.
// Optional LL_AUTOTICK_EN: an internal TICK_DIV prescaler generates the step requests instead of tick.
module ll_step_engine #(
  parameter int unsigned         DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] ALT0      = 16'h4500,
  parameter logic [4*DIGITS-1:0] VEL0      = 16'h0000,
  parameter logic [4*DIGITS-1:0] FUEL0     = 16'h0800,
  parameter logic [3:0]          GRAVITY   = 4'h5,
  parameter logic [4*DIGITS-1:0] CRASH_VEL = 16'h0030,
  parameter int unsigned         TICK_DIV  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [3:0]            thrust,
  output logic [4*DIGITS-1:0]   alt,
  output logic [4*DIGITS-1:0]   vel,
  output logic [4*DIGITS-1:0]   fuel,
  output logic                  busy,
  output logic                  done,
  output logic                  land,
  output logic                  crash,
  output logic                  overrun
);

  localparam int unsigned   DATA_W   = 4 * DIGITS;
  localparam int unsigned   CW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALT, S_VELG, S_VELT, S_FUEL, S_CHECK, S_LANDED, S_CRASHED
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   alt_q, vel_q, fuel_q;
  logic [DATA_W-1:0]   w_alt_q, w_vel_q, w_fuel_q;
  logic [3:0]          thr_q;
  logic                carry_q;
  logic                done_q, land_q, crash_q, overrun_q;

  logic                step_req;
  logic                busy_s, arith_st, last_dig;
  logic [3:0]          op_a, op_b, sum_dig, thr_sat, thr_eff;
  logic                op_sub, cin, cout;
  logic [4:0]          add_res;
  logic                touch, too_fast;

  // One BCD digit of a + b + cin; bit 4 of the result is the decimal carry-out.
  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin_i);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin_i};
    if (s > 5'd9) s = s + 5'd6;
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] nines(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) r[i*4 +: 4] = 4'd9 - v[i*4 +: 4];
    return r;
  endfunction

  function automatic logic [3:0] dig(input logic [DATA_W-1:0] v, input logic [CW-1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

`ifdef LL_AUTOTICK_EN
  localparam int unsigned TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TDW-1:0] TDIV_LAST = TDW'(TICK_DIV - 1);
  logic [TDW-1:0] tdiv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tdiv_q <= '0;
    else if (tdiv_q == TDIV_LAST) tdiv_q <= '0;
    else                        tdiv_q <= tdiv_q + 1'b1;
  end

  assign step_req = (tdiv_q == TDIV_LAST);
`else
  assign step_req = tick;
`endif

  // Thrust limited to a legal digit, then to the fuel that is left.
  always_comb begin
    thr_sat = (thrust > 4'd9) ? 4'd9 : thrust;
    if (fuel_q == '0)                       thr_eff = 4'd0;
    else if (fuel_q < DATA_W'(thr_sat))     thr_eff = fuel_q[3:0];
    else                                    thr_eff = thr_sat;
  end

  assign last_dig = (cnt_q == LAST_DIG);

  // Touchdown when altitude is zero or negative; crash when |w_vel| > CRASH_VEL,
  // i.e. nines(w_vel) = |w_vel| - 1 >= CRASH_VEL for a negative velocity.
  assign touch    = (w_alt_q[DATA_W-1 -: 4] >= 4'd5) || (w_alt_q == '0);
  assign too_fast = (w_vel_q[DATA_W-1 -: 4] >= 4'd5) && (nines(w_vel_q) >= CRASH_VEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (step_req) state_d = S_ALT;
      S_ALT:   if (last_dig) state_d = S_VELG;
      S_VELG:  if (last_dig) state_d = S_VELT;
      S_VELT:  if (last_dig) state_d = S_FUEL;
      S_FUEL:  if (last_dig) state_d = S_CHECK;
      S_CHECK: begin
        if (!touch)        state_d = S_IDLE;
        else if (too_fast) state_d = S_CRASHED;
        else               state_d = S_LANDED;
      end
      default: state_d = state_q;
    endcase
    cnt_d = (arith_st && !last_dig) ? cnt_q + 1'b1 : '0;
  end

  // Operand routing into the single shared digit adder.
  always_comb begin
    busy_s   = 1'b0;
    arith_st = 1'b0;
    op_sub   = 1'b0;
    op_a     = dig(w_alt_q, cnt_q);
    op_b     = 4'd0;
    case (state_q)
      S_ALT: begin
        busy_s   = 1'b1;
        arith_st = 1'b1;
        op_b     = dig(w_vel_q, cnt_q);
      end
      S_VELG: begin
        busy_s   = 1'b1;
        arith_st = 1'b1;
        op_sub   = 1'b1;
        op_a     = dig(w_vel_q, cnt_q);
        op_b     = (cnt_q == '0) ? GRAVITY : 4'd0;
      end
      S_VELT: begin
        busy_s   = 1'b1;
        arith_st = 1'b1;
        op_a     = dig(w_vel_q, cnt_q);
        op_b     = (cnt_q == '0) ? thr_q : 4'd0;
      end
      S_FUEL: begin
        busy_s   = 1'b1;
        arith_st = 1'b1;
        op_sub   = 1'b1;
        op_a     = dig(w_fuel_q, cnt_q);
        op_b     = (cnt_q == '0) ? thr_q : 4'd0;
      end
      S_CHECK: busy_s = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cin     = (cnt_q == '0) ? op_sub : carry_q;
    add_res = bcd_add(op_a, op_sub ? (4'd9 - op_b) : op_b, cin);
    sum_dig = add_res[3:0];
    cout    = add_res[4];
  end

  // Working registers: loaded on accept, then rewritten one digit per clock.
  always_ff @(posedge clk) begin
    carry_q <= cout;
    case (state_q)
      S_IDLE: begin
        if (step_req) begin
          w_alt_q  <= alt_q;
          w_vel_q  <= vel_q;
          w_fuel_q <= fuel_q;
          thr_q    <= thr_eff;
        end
      end
      S_ALT:          w_alt_q[{cnt_q, 2'b00} +: 4]  <= sum_dig;
      S_VELG, S_VELT: w_vel_q[{cnt_q, 2'b00} +: 4]  <= sum_dig;
      S_FUEL:         w_fuel_q[{cnt_q, 2'b00} +: 4] <= sum_dig;
      default: ;
    endcase
  end

  // Commit boundary: architectural state only changes on the CHECK edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alt_q     <= ALT0;
      vel_q     <= VEL0;
      fuel_q    <= FUEL0;
      done_q    <= 1'b0;
      land_q    <= 1'b0;
      crash_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_CHECK);
      if (step_req && busy_s) overrun_q <= 1'b1;
      if (state_q == S_CHECK) begin
        fuel_q <= w_fuel_q;
        if (touch) begin
          alt_q <= '0;
          vel_q <= '0;
          if (too_fast) crash_q <= 1'b1;
          else          land_q  <= 1'b1;
        end else begin
          alt_q <= w_alt_q;
          vel_q <= w_vel_q;
        end
      end
    end
  end

  assign alt     = alt_q;
  assign vel     = vel_q;
  assign fuel    = fuel_q;
  assign busy    = busy_s;
  assign done    = done_q;
  assign land    = land_q;
  assign crash   = crash_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ll_step_engine.sv
// tb_ll_step_engine: directed scoreboard bench for ll_step_engine (tick-port build).
module tb_ll_step_engine;

  localparam int N   = 5;
  localparam int LAT = 18;

  typedef struct packed {
    logic [15:0] alt;
    logic [15:0] vel;
    logic [15:0] fuel;
    logic        land;
    logic        crash;
    int          due;
  } exp_t;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic [N-1:0] tick_v = '0;
  logic [3:0]   thrust = 4'd0;
  logic [15:0]  alt_w  [N];
  logic [15:0]  vel_w  [N];
  logic [15:0]  fuel_w [N];
  logic [N-1:0] busy_w, done_w, land_w, crash_w, ovr_w;

  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt [N] = '{default: 0};
  int   dc       [N];
  exp_t sb_q     [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: defaults, 1: low fuel, 2: soft landing, 3: landing at exactly -30, 4: crash
  ll_step_engine u_dut0 (.clk(clk), .rst(rst), .tick(tick_v[0]), .thrust(thrust),
    .alt(alt_w[0]), .vel(vel_w[0]), .fuel(fuel_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .land(land_w[0]), .crash(crash_w[0]), .overrun(ovr_w[0]));

  ll_step_engine #(.FUEL0(16'h0003)) u_dut1 (.clk(clk), .rst(rst), .tick(tick_v[1]),
    .thrust(thrust), .alt(alt_w[1]), .vel(vel_w[1]), .fuel(fuel_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .land(land_w[1]), .crash(crash_w[1]), .overrun(ovr_w[1]));

  ll_step_engine #(.ALT0(16'h0010), .VEL0(16'h9980)) u_dut2 (.clk(clk), .rst(rst),
    .tick(tick_v[2]), .thrust(thrust), .alt(alt_w[2]), .vel(vel_w[2]), .fuel(fuel_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .land(land_w[2]), .crash(crash_w[2]), .overrun(ovr_w[2]));

  ll_step_engine #(.ALT0(16'h0010), .VEL0(16'h9975)) u_dut3 (.clk(clk), .rst(rst),
    .tick(tick_v[3]), .thrust(thrust), .alt(alt_w[3]), .vel(vel_w[3]), .fuel(fuel_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .land(land_w[3]), .crash(crash_w[3]), .overrun(ovr_w[3]));

  ll_step_engine #(.ALT0(16'h0010), .VEL0(16'h9960)) u_dut4 (.clk(clk), .rst(rst),
    .tick(tick_v[4]), .thrust(thrust), .alt(alt_w[4]), .vel(vel_w[4]), .fuel(fuel_w[4]),
    .busy(busy_w[4]), .done(done_w[4]), .land(land_w[4]), .crash(crash_w[4]), .overrun(ovr_w[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int k = 0; k < N; k++) p += sb_q[k].size();
    return p;
  endfunction

  // Accepted step: pulse tick on one instance and queue the committed result it must produce.
  // done must be high in the LAT-th cycle, counting the cycle that starts at the accept edge as 1.
  task automatic step(input int k, input logic [15:0] a, input logic [15:0] v,
                      input logic [15:0] f, input logic l, input logic c);
    exp_t e;
    @(negedge clk);
    tick_v[k] = 1'b1;
    @(posedge clk);
    #1;
    e.alt = a; e.vel = v; e.fuel = f; e.land = l; e.crash = c;
    e.due = cyc + LAT - 1;
    sb_q[k].push_back(e);
    @(negedge clk);
    tick_v[k] = 1'b0;
  endtask

  task automatic raw_tick(input logic [N-1:0] mask);
    @(negedge clk);
    tick_v = mask;
    @(negedge clk);
    tick_v = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, pending(), 0);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (done_w[k] === 1'b1) begin
          done_cnt[k]++;
          chk($sformatf("d%0d_done_expected", k), 32'(sb_q[k].size() != 0), 32'd1);
          if (sb_q[k].size() != 0) begin
            e = sb_q[k].pop_front();
            chk($sformatf("d%0d_latency", k), cyc, e.due);
            chk($sformatf("d%0d_alt", k), alt_w[k], e.alt);
            chk($sformatf("d%0d_vel", k), vel_w[k], e.vel);
            chk($sformatf("d%0d_fuel", k), fuel_w[k], e.fuel);
            chk($sformatf("d%0d_land", k), land_w[k], e.land);
            chk($sformatf("d%0d_crash", k), crash_w[k], e.crash);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_async_alt", alt_w[0], 16'h4500);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_alt", alt_w[0], 16'h4500);
    chk("rst_vel", vel_w[0], 16'h0000);
    chk("rst_fuel", fuel_w[0], 16'h0800);
    chk("rst_fuel_low", fuel_w[1], 16'h0003);
    chk("rst_vel_land", vel_w[2], 16'h9980);
    chk("rst_flags", {busy_w, done_w, land_w, crash_w, ovr_w}, 0);

    // Single step with thrust 5 from defaults
    thrust = 4'd5;
    step(0, 16'h4500, 16'h0000, 16'h0795, 1'b0, 1'b0);
    chk("t1_busy", busy_w[0], 1'b1);
    repeat (9) @(negedge clk);
    chk("t1_mid_vel", vel_w[0], 16'h0000);
    chk("t1_mid_fuel", fuel_w[0], 16'h0800);
    drain("t1");
    chk("t1_busy_after", busy_w[0], 1'b0);
    chk("t1_overrun", ovr_w[0], 1'b0);

    // Free fall: two ticks 30 cycles apart, altitude wraps through 9995
    do_rst();
    thrust = 4'd0;
    step(0, 16'h4500, 16'h9995, 16'h0800, 1'b0, 1'b0);
    repeat (28) @(negedge clk);
    step(0, 16'h4495, 16'h9990, 16'h0800, 1'b0, 1'b0);
    drain("t2");

    // Thrust limited by the fuel left, then by empty tank
    thrust = 4'd5;
    step(1, 16'h4500, 16'h9998, 16'h0000, 1'b0, 1'b0);
    drain("t3a");
    step(1, 16'h4498, 16'h9993, 16'h0000, 1'b0, 1'b0);
    drain("t3b");

    // Touchdown: soft, exactly at the threshold, and too fast
    thrust = 4'd0;
    step(2, 16'h0000, 16'h0000, 16'h0800, 1'b1, 1'b0);
    drain("t4a");
    step(3, 16'h0000, 16'h0000, 16'h0800, 1'b1, 1'b0);
    drain("t4b");
    step(4, 16'h0000, 16'h0000, 16'h0800, 1'b0, 1'b1);
    drain("t4c");

    // Terminal states swallow ticks without overrun
    for (int k = 0; k < N; k++) dc[k] = done_cnt[k];
    raw_tick(5'b11100);
    repeat (25) @(negedge clk);
    chk("abs_done", done_cnt[2] + done_cnt[3] + done_cnt[4], dc[2] + dc[3] + dc[4]);
    chk("abs_overrun", ovr_w[4:2], 3'b000);
    chk("abs_land", land_w[4:2], 3'b011);
    chk("abs_crash", crash_w[4:2], 3'b100);
    chk("abs_busy", busy_w[4:2], 3'b000);

    // Tick while busy: ignored, flagged
    do_rst();
    thrust = 4'd5;
    dc[0] = done_cnt[0];
    step(0, 16'h4500, 16'h0000, 16'h0795, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    raw_tick(5'b00001);
    drain("t5");
    repeat (20) @(negedge clk);
    chk("t5_done_count", done_cnt[0] - dc[0], 1);
    chk("t5_overrun", ovr_w[0], 1'b1);

    // Tick landing on the commit edge: ignored, flagged, next step still works
    do_rst();
    chk("t5b_overrun_clr", ovr_w[0], 1'b0);
    dc[0] = done_cnt[0];
    step(0, 16'h4500, 16'h0000, 16'h0795, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    raw_tick(5'b00001);
    drain("t5b");
    repeat (20) @(negedge clk);
    chk("t5b_done_count", done_cnt[0] - dc[0], 1);
    chk("t5b_overrun", ovr_w[0], 1'b1);
    step(0, 16'h4500, 16'h0000, 16'h0790, 1'b0, 1'b0);
    drain("t5c");

    // Reset in the middle of a step aborts it
    do_rst();
    dc[0] = done_cnt[0];
    raw_tick(5'b00001);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_alt", alt_w[0], 16'h4500);
    chk("t6_vel", vel_w[0], 16'h0000);
    chk("t6_fuel", fuel_w[0], 16'h0800);
    chk("t6_busy", busy_w[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("t6_no_done", done_cnt[0], dc[0]);
    step(0, 16'h4500, 16'h0000, 16'h0795, 1'b0, 1'b0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ll_step_engine.md
Name: ll_step_engine

Overview:
Parametrised, digit-serial successor to the lunar-lander memory/ALU/control trio. It holds the lander state (altitude, velocity, fuel) as signed N-digit BCD (ten's complement) and runs one physics step per accepted tick. Each step is computed one BCD digit per clock through a single shared digit adder. Landing, crash and fuel exhaustion are resolved inside the block; the display and input-sync logic sit outside it.

Parameters:
DIGITS, 4, BCD digits per quantity (2..8); all data ports are 4*DIGITS bits wide.
ALT0, 16'h4500, reset altitude (BCD, width 4*DIGITS).
VEL0, 16'h0000, reset velocity (ten's-complement BCD).
FUEL0, 16'h0800, reset fuel (BCD, non-negative).
GRAVITY, 4'h5, BCD digit subtracted from velocity every step.
CRASH_VEL, 16'h0030, BCD magnitude of the crash threshold.
TICK_DIV, 100, prescaler period in clk cycles; used only when LL_AUTOTICK_EN is defined.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
tick  in  1  step request, one-cycle pulse from the synchroniser.
thrust  in  4  requested thrust, one BCD digit.
alt  out  4*DIGITS  committed altitude.
vel  out  4*DIGITS  committed velocity (ten's complement).
fuel  out  4*DIGITS  committed fuel.
busy  out  1  high while a step is in progress.
done  out  1  one-cycle pulse when a step commits.
land  out  1  sticky; lander touched down safely.
crash  out  1  sticky; lander touched down too fast.
overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset values: alt=ALT0, vel=VEL0, fuel=FUEL0; busy, done, land, crash, overrun all 0; FSM in IDLE; digit counter 0.
- Sign rule: a value is negative when its most-significant digit is >= 5. Subtraction is nine's complement of the subtrahend plus a carry-in of 1.
- States: IDLE, ALT, VELG, VELT, FUEL, CHECK, LANDED, CRASHED.
- IDLE with tick=1:
  - Latch thr_eff as follows: thrust values A-F are treated as 9; if fuel < thrust, thr_eff = fuel (low digit only; fuel < 10 in that case); if fuel = 0, thr_eff = 0.
  - Copy alt/vel/fuel into working registers. Go to ALT with digit counter 0. busy goes high on the next cycle.
- ALT: w_alt = alt + vel. VELG: w_vel = vel - GRAVITY. VELT: w_vel = w_vel + thr_eff. FUEL: w_fuel = fuel - thr_eff.
  - Each of these states takes exactly DIGITS cycles, least-significant digit first.
  - The carry register is cleared (add) or set (subtract) at digit 0 of each state.
  - The final carry-out is discarded, giving mod-10^DIGITS wrap.
- CHECK (1 cycle):
  - If w_alt is negative or zero: alt=0, vel=0, fuel=w_fuel. crash=1 and go to CRASHED if w_vel < -CRASH_VEL (strict); otherwise land=1 and go to LANDED.
  - Otherwise commit alt=w_alt, vel=w_vel, fuel=w_fuel and return to IDLE.
  - done pulses in the cycle after CHECK. busy drops in that same cycle.
- Latency: the tick accept edge to the done-high cycle is 4*DIGITS+2 cycles (18 for DIGITS=4). alt/vel/fuel change only at the commit edge and never show partial digits.
- A tick while busy is ignored (not queued) and sets overrun.
- LANDED and CRASHED are absorbing: tick is ignored there, overrun is not set, and the outputs hold until rst.
- Simultaneous tick and commit edge: the tick is ignored (the FSM is not in IDLE that cycle) and sets overrun.
- rst asserted mid-step aborts immediately; all values return to reset values with no done pulse.

Optional Feature:
LL_AUTOTICK_EN:
- Defined: an internal counter generates a step request every TICK_DIV cycles (counter 0..TICK_DIV-1, request when it wraps). The tick port is ignored. The counter resets to 0 and keeps running in every state.
- Undefined: steps come only from the tick port, and no counter logic exists.

Test Plan:
1. Defaults, thrust=5, single tick -> done exactly 18 cycles later; alt=4500, vel=0000, fuel=0795; land=crash=0.
2. Defaults, thrust=0, two ticks spaced 30 cycles apart -> after the first: vel=9995, alt=4500; after the second: alt=4495, vel=9990, fuel=0800.
3. FUEL0=0003, thrust=5 -> fuel=0000, vel=9998. Next tick with thrust=5 -> thr_eff=0, vel=9993, fuel=0000.
4. ALT0=0010, VEL0=9980, thrust=0 -> alt=0000, vel=0000, land=1, crash=0. Repeat with VEL0=9975 (w_vel=9970, exactly -30) -> land=1. Repeat with VEL0=9960 -> crash=1, land=0.
5. Tick pulsed 5 cycles after an accepted tick -> the step result is unchanged, overrun=1, and only one done pulse occurs.
6. rst pulsed 10 cycles into a step -> alt=4500, vel=0000, fuel=0800, busy=0, and no done pulse. A fresh tick afterwards completes normally.
